// File: rtl/fpu_round_arbiter_pkg.sv
// Shared types for the FPU rounding arbiter: rounding-mode codes, flag bit positions, request bundle.
// Widths default to single precision; the struct follows the package localparams.
package fpu_round_pkg;

    localparam int P_STD  = 31;
    localparam int P_MAN  = 22;
    localparam int P_EXP  = 7;
    localparam int P_TAGW = 5;
    localparam int P_NOW  = 2*P_MAN + P_EXP + 7;

    localparam logic [2:0] RM_RNE = 3'b000;
    localparam logic [2:0] RM_RTZ = 3'b001;
    localparam logic [2:0] RM_RDN = 3'b010;
    localparam logic [2:0] RM_RUP = 3'b011;
    localparam logic [2:0] RM_RMM = 3'b100;
    localparam logic [2:0] RM_DYN = 3'b111;

    localparam int OVF = 2;
    localparam int UDF = 1;
    localparam int NX  = 0;

    typedef struct packed {
        logic [P_NOW-1:0]  no;
        logic              sticky;
        logic [2:0]        rm;
        logic [P_TAGW-1:0] tag;
    } req_t;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } out_state_e;

endpackage

// File: rtl/fpu_round_arbiter_if.sv
// Two valid/ready request channels (FMUL, FMADD) and one valid/ready result channel.
// slave = the arbiter side, master = the producers/consumer side.
interface fpu_round_arbiter_if
    import fpu_round_pkg::*;
#(
    parameter int STD  = P_STD,
    parameter int MAN  = P_MAN,
    parameter int EXP  = P_EXP,
    parameter int TAGW = P_TAGW
);
    logic                   req0_valid;
    logic                   req0_ready;
    logic [2*MAN+EXP+6:0]   req0_no;
    logic                   req0_sticky;
    logic [2:0]             req0_rm;
    logic [TAGW-1:0]        req0_tag;

    logic                   req1_valid;
    logic                   req1_ready;
    logic [2*MAN+EXP+6:0]   req1_no;
    logic                   req1_sticky;
    logic [2:0]             req1_rm;
    logic [TAGW-1:0]        req1_tag;

    logic                   out_valid;
    logic                   out_ready;
    logic [STD:0]           out_no;
    logic [2:0]             out_flags;
    logic                   out_src;
    logic [TAGW-1:0]        out_tag;

    modport slave (
        input  req0_valid, req0_no, req0_sticky, req0_rm, req0_tag,
        output req0_ready,
        input  req1_valid, req1_no, req1_sticky, req1_rm, req1_tag,
        output req1_ready,
        input  out_ready,
        output out_valid, out_no, out_flags, out_src, out_tag
    );

    modport master (
        output req0_valid, req0_no, req0_sticky, req0_rm, req0_tag,
        input  req0_ready,
        output req1_valid, req1_no, req1_sticky, req1_rm, req1_tag,
        input  req1_ready,
        output out_ready,
        input  out_valid, out_no, out_flags, out_src, out_tag
    );

endinterface

// File: rtl/fpu_round_arbiter_core.sv
// Combinational rounding of {sign, 9b exp, 2*MAN+4 b mantissa} to a packed float plus {ovf, udf, nx}.
// Zero latency, no flow control.
module fpu_round_core
    import fpu_round_pkg::*;
#(
    parameter int STD = P_STD,
    parameter int MAN = P_MAN,
    parameter int EXP = P_EXP
) (
    input  logic [2*MAN+EXP+6:0] i_no,
    input  logic                 i_sticky,
    input  logic [2:0]           i_rm,
    output logic [STD:0]         o_no,
    output logic [2:0]           o_flags
);
    localparam int MW = 2*MAN + 4;

    logic            w_sign;
    logic [EXP+1:0]  w_exp;
    logic [MW-1:0]   w_man;
    logic [MAN+1:0]  w_kept;
    logic [MAN+1:0]  w_rnd;
    logic [EXP:0]    w_exp_out;
    logic            w_l, w_g, w_r, w_s, w_any;
    logic            w_ovf, w_udf, w_inc_raw, w_inc, w_exp_inc, w_to_inf;

    assign {w_sign, w_exp, w_man} = i_no;

    assign w_kept = w_man[MW-1:MAN+2];
    assign w_l    = w_man[MAN+2];
    assign w_g    = w_man[MAN+1];
    assign w_r    = w_man[MAN];
    assign w_s    = |w_man[MAN-1:0];
    assign w_any  = w_g | w_r | w_s | i_sticky;

    assign w_ovf  = w_exp[EXP+1] | (&w_exp[EXP:0]);
    assign w_udf  = ~(|w_exp) & ~w_kept[MAN+1];

    always_comb begin
        w_inc_raw = 1'b0;
        case (i_rm)
            RM_RNE:         w_inc_raw = w_g & (w_r | w_s | w_l);
            RM_RMM:         w_inc_raw = w_g;
            RM_RUP:         w_inc_raw = ~w_sign & w_any;
            RM_RDN:         w_inc_raw = w_sign & w_any;
            RM_RTZ, RM_DYN: w_inc_raw = 1'b0;
            default:        w_inc_raw = 1'b0;
        endcase
    end

    // An overflowing exponent is replaced wholesale, so rounding up would only disturb the mantissa.
    assign w_inc     = w_inc_raw & ~w_ovf;
    assign w_rnd     = w_kept + {{(MAN+1){1'b0}}, w_inc};
    assign w_exp_inc = ~w_kept[MAN+1] & w_rnd[MAN+1];
    assign w_exp_out = w_exp[EXP:0] + {{EXP{1'b0}}, w_exp_inc};

    assign w_to_inf = (i_rm == RM_RNE) | (i_rm == RM_RMM) |
                      ((i_rm == RM_RUP) & ~w_sign) | ((i_rm == RM_RDN) & w_sign);

    always_comb begin
        o_no = {w_sign, w_exp_out, w_rnd[MAN:0]};
        if (w_ovf) begin
            if (w_to_inf) o_no = {w_sign, {(EXP+1){1'b1}}, {(MAN+1){1'b0}}};
            else          o_no = {w_sign, {EXP{1'b1}}, 1'b0, {(MAN+1){1'b1}}};
        end
        o_flags      = 3'b000;
        o_flags[OVF] = w_ovf;
        o_flags[UDF] = w_udf;
        o_flags[NX]  = w_any | w_ovf;
    end

endmodule

// File: rtl/fpu_round_arbiter.sv
// Round-robin share of one rounding datapath between FMUL (req0) and FMADD (req1); FPU_ROUND_DYN_RM_EN adds csr_frm for rm=DYN.
// Latency 1 cycle, 1 result/cycle; reqN_ready drops while the result register is held and neither drained nor flushed.
module fpu_round_arbiter
    import fpu_round_pkg::*;
#(
    parameter int STD  = P_STD,
    parameter int MAN  = P_MAN,
    parameter int EXP  = P_EXP,
    parameter int TAGW = P_TAGW
) (
    input  logic                clk,
    input  logic                rst_l,
    fpu_round_arbiter_if.slave  bus,
    input  logic                flush,
`ifdef FPU_ROUND_DYN_RM_EN
    input  logic [2:0]          csr_frm,
`endif
    input  logic                fflags_clr,
    output logic [2:0]          fflags_acc
);
    out_state_e       r_state, w_state_nxt;
    logic             r_last_grant;
    logic [STD:0]     r_out_no;
    logic [2:0]       r_out_flags;
    logic             r_out_src;
    logic [TAGW-1:0]  r_out_tag;
    logic [2:0]       r_fflags_acc;

    logic             w_can_accept, w_grant0, w_grant1, w_fire, w_consume;
    req_t             w_sel;
    logic [2:0]       w_rm_eff;
    logic [STD:0]     w_rnd_no;
    logic [2:0]       w_rnd_flags;

    assign w_can_accept = (r_state == ST_EMPTY) | bus.out_ready | flush;

    // With both valid, the port that did not win last time goes first.
    assign w_grant0 = bus.req0_valid & (~bus.req1_valid | r_last_grant);
    assign w_grant1 = bus.req1_valid & (~bus.req0_valid | ~r_last_grant);
    assign w_fire   = w_can_accept & (w_grant0 | w_grant1);

    assign bus.req0_ready = w_can_accept & w_grant0;
    assign bus.req1_ready = w_can_accept & w_grant1;

    assign w_sel = w_grant1 ? {bus.req1_no, bus.req1_sticky, bus.req1_rm, bus.req1_tag}
                            : {bus.req0_no, bus.req0_sticky, bus.req0_rm, bus.req0_tag};

`ifdef FPU_ROUND_DYN_RM_EN
    assign w_rm_eff = (w_sel.rm == RM_DYN) ? csr_frm : w_sel.rm;
`else
    assign w_rm_eff = w_sel.rm;
`endif

    fpu_round_core #(
        .STD (STD),
        .MAN (MAN),
        .EXP (EXP)
    ) u_core (
        .i_no     (w_sel.no),
        .i_sticky (w_sel.sticky),
        .i_rm     (w_rm_eff),
        .o_no     (w_rnd_no),
        .o_flags  (w_rnd_flags)
    );

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) r_state <= ST_EMPTY;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_EMPTY: if (w_fire) w_state_nxt = ST_FULL;
            ST_FULL:  if (!w_fire && (bus.out_ready || flush)) w_state_nxt = ST_EMPTY;
            default:  w_state_nxt = ST_EMPTY;
        endcase
    end

    // A flushed result is never counted, even when the consumer was ready.
    assign w_consume = (r_state == ST_FULL) & bus.out_ready & ~flush;

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_last_grant <= 1'b1;
            r_out_no     <= '0;
            r_out_flags  <= 3'b000;
            r_out_src    <= 1'b0;
            r_out_tag    <= '0;
            r_fflags_acc <= 3'b000;
        end else begin
            if (w_fire) begin
                r_last_grant <= w_grant1;
                r_out_no     <= w_rnd_no;
                r_out_flags  <= w_rnd_flags;
                r_out_src    <= w_grant1;
                r_out_tag    <= w_sel.tag;
            end
            r_fflags_acc <= (fflags_clr ? 3'b000 : r_fflags_acc) |
                            (w_consume ? r_out_flags : 3'b000);
        end
    end

    assign bus.out_valid = (r_state == ST_FULL);
    assign bus.out_no    = r_out_no;
    assign bus.out_flags = r_out_flags;
    assign bus.out_src   = r_out_src;
    assign bus.out_tag   = r_out_tag;
    assign fflags_acc    = r_fflags_acc;

endmodule

// File: tb/tb_fpu_round_arbiter.sv
// Directed bench for fpu_round_arbiter: scoreboard of expected results pushed on each accepted request.
// Honours FPU_ROUND_DYN_RM_EN when the build defines it.
module tb_fpu_round_arbiter;
    import fpu_round_pkg::*;

    logic       clk = 1'b0;
    logic       rst_l;
    logic       flush;
    logic       fflags_clr;
    logic [2:0] fflags_acc;
`ifdef FPU_ROUND_DYN_RM_EN
    logic [2:0] csr_frm;
`endif

    fpu_round_arbiter_if bus ();

    fpu_round_arbiter dut (
        .clk        (clk),
        .rst_l      (rst_l),
        .bus        (bus),
        .flush      (flush),
`ifdef FPU_ROUND_DYN_RM_EN
        .csr_frm    (csr_frm),
`endif
        .fflags_clr (fflags_clr),
        .fflags_acc (fflags_acc)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] no;
        logic [2:0]  fl;
        logic        src;
        logic [4:0]  tag;
    } exp_t;

    localparam logic [57:0] V_A = {1'b0, 9'h07F, 48'h800000_800000};
    localparam logic [57:0] V_B = {1'b0, 9'h0FF, 48'h800000_800000};
    localparam logic [57:0] V_C = {1'b0, 9'h080, 48'h800000_000000};
    localparam logic [57:0] V_D = {1'b0, 9'h000, 48'h7FFFFF_800000};
    localparam logic [57:0] V_E = {1'b0, 9'h07F, 48'h800000_000000};

    exp_t        sb [$];
    logic [31:0] e_no  [2];
    logic [2:0]  e_fl  [2];
    logic [4:0]  e_tag [2];
    int          n_checks = 0;
    int          n_pass   = 0;
    int          n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int p, input logic v, input logic [57:0] no, input logic st,
                           input logic [2:0] rm, input logic [4:0] tag,
                           input logic [31:0] eno, input logic [2:0] efl);
        if (p == 0) begin
            bus.req0_valid = v; bus.req0_no = no; bus.req0_sticky = st;
            bus.req0_rm = rm;   bus.req0_tag = tag;
        end else begin
            bus.req1_valid = v; bus.req1_no = no; bus.req1_sticky = st;
            bus.req1_rm = rm;   bus.req1_tag = tag;
        end
        e_no[p] = eno; e_fl[p] = efl; e_tag[p] = tag;
    endtask

    // Negedge sample: retire the held result (compare or drop on flush), then record new acceptances.
    task automatic at_neg();
        exp_t e;
        @(negedge clk);
        if (bus.out_valid === 1'b1 && (flush === 1'b1 || bus.out_ready === 1'b1)) begin
            check("sb_has_entry", 64'(sb.size() > 0), 64'd1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                if (flush !== 1'b1) begin
                    check($sformatf("out_no_tag%0d", e.tag),    64'(bus.out_no),    64'(e.no));
                    check($sformatf("out_flags_tag%0d", e.tag), 64'(bus.out_flags), 64'(e.fl));
                    check($sformatf("out_src_tag%0d", e.tag),   64'(bus.out_src),   64'(e.src));
                    check($sformatf("out_tag_tag%0d", e.tag),   64'(bus.out_tag),   64'(e.tag));
                end
            end
        end
        if (bus.req0_valid === 1'b1 && bus.req0_ready === 1'b1)
            sb.push_back({e_no[0], e_fl[0], 1'b0, e_tag[0]});
        if (bus.req1_valid === 1'b1 && bus.req1_ready === 1'b1)
            sb.push_back({e_no[1], e_fl[1], 1'b1, e_tag[1]});
    endtask

    task automatic to_pos();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int p, input logic [57:0] no, input logic st, input logic [2:0] rm,
                        input logic [4:0] tag, input logic [31:0] eno, input logic [2:0] efl);
        set_req(p, 1'b1, no, st, rm, tag, eno, efl);
        at_neg();
        check($sformatf("rdy%0d_tag%0d", p, tag),
              64'(p == 0 ? bus.req0_ready : bus.req1_ready), 64'd1);
        to_pos();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        at_neg();
        to_pos();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_l = 1'b0; flush = 1'b0; fflags_clr = 1'b0;
        bus.out_ready = 1'b1;
        set_req(0, 1'b0, '0, 1'b0, 3'b000, 5'd0, 32'h0, 3'b000);
        set_req(1, 1'b0, '0, 1'b0, 3'b000, 5'd0, 32'h0, 3'b000);
`ifdef FPU_ROUND_DYN_RM_EN
        csr_frm = RM_RMM;
`endif
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_out_no",    64'(bus.out_no),    64'd0);
        check("rst_out_flags", 64'(bus.out_flags), 64'd0);
        check("rst_out_src",   64'(bus.out_src),   64'd0);
        check("rst_out_tag",   64'(bus.out_tag),   64'd0);
        check("rst_fflags",    64'(fflags_acc),    64'd0);
        rst_l = 1'b1;

        // Single requests across rounding modes and exception cases.
        send(0, V_A, 1'b0, RM_RNE, 5'd3,  32'h3F800000, 3'b001);
        send(0, V_A, 1'b0, RM_RMM, 5'd4,  32'h3F800001, 3'b001);
        send(1, V_B, 1'b0, RM_RNE, 5'd7,  32'h7F800000, 3'b101);
        send(1, V_B, 1'b0, RM_RTZ, 5'd8,  32'h7F7FFFFF, 3'b101);
        send(0, V_D, 1'b0, RM_RNE, 5'd12, 32'h00800000, 3'b011);
        send(1, V_E, 1'b1, RM_RUP, 5'd13, 32'h3F800001, 3'b001);
`ifdef FPU_ROUND_DYN_RM_EN
        send(1, V_A, 1'b0, RM_DYN, 5'd14, 32'h3F800001, 3'b001);
`else
        send(1, V_A, 1'b0, RM_DYN, 5'd14, 32'h3F800000, 3'b001);
`endif
        at_neg();
        check("acc_after_singles", 64'(fflags_acc), 64'b111);
        fflags_clr = 1'b1;
        to_pos();
        fflags_clr = 1'b0;
        at_neg();
        check("acc_after_clear", 64'(fflags_acc), 64'd0);
        to_pos();

        // Both ports hammering: grants alternate starting with req0.
        set_req(0, 1'b1, V_C, 1'b0, RM_RNE, 5'd1, 32'h40000000, 3'b000);
        set_req(1, 1'b1, V_C, 1'b0, RM_RNE, 5'd2, 32'h40000000, 3'b000);
        for (int k = 0; k < 4; k++) begin
            at_neg();
            check($sformatf("alt_rdy0_%0d", k), 64'(bus.req0_ready), 64'(k % 2 == 0));
            check($sformatf("alt_rdy1_%0d", k), 64'(bus.req1_ready), 64'(k % 2 == 1));
            to_pos();
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        at_neg();
        to_pos();

        // Hold a result under backpressure, then flush it while loading a new one.
        bus.out_ready = 1'b0;
        set_req(0, 1'b1, V_A, 1'b0, RM_RNE, 5'd4, 32'h3F800000, 3'b001);
        at_neg();
        to_pos();
        set_req(1, 1'b1, V_B, 1'b0, RM_RNE, 5'd9, 32'h7F800000, 3'b101);
        for (int k = 0; k < 2; k++) begin
            at_neg();
            check($sformatf("hold_rdy0_%0d", k), 64'(bus.req0_ready), 64'd0);
            check($sformatf("hold_rdy1_%0d", k), 64'(bus.req1_ready), 64'd0);
            check($sformatf("hold_no_%0d", k),   64'(bus.out_no),     64'h3F800000);
            to_pos();
        end
        bus.req0_valid = 1'b0;
        flush = 1'b1;
        at_neg();
        check("flush_rdy1", 64'(bus.req1_ready), 64'd1);
        to_pos();
        flush = 1'b0;
        bus.req1_valid = 1'b0;
        at_neg();
        check("flush_out_valid", 64'(bus.out_valid), 64'd1);
        check("flush_acc",       64'(fflags_acc),    64'd0);
        to_pos();
        bus.out_ready = 1'b1;
        at_neg();
        to_pos();
        at_neg();
        check("acc_after_flush_consume", 64'(fflags_acc), 64'b101);
        to_pos();

        // Clear coinciding with a consume keeps only the new flags.
        set_req(0, 1'b1, V_A, 1'b0, RM_RNE, 5'd5, 32'h3F800000, 3'b001);
        at_neg();
        to_pos();
        bus.req0_valid = 1'b0;
        fflags_clr = 1'b1;
        at_neg();
        to_pos();
        fflags_clr = 1'b0;
        at_neg();
        check("acc_clr_and_consume", 64'(fflags_acc), 64'b001);
        to_pos();

        // Reset while a result is held.
        bus.out_ready = 1'b0;
        set_req(0, 1'b1, V_A, 1'b0, RM_RNE, 5'd6, 32'h3F800000, 3'b001);
        at_neg();
        to_pos();
        bus.req0_valid = 1'b0;
        #2;
        check("pre_rst_out_valid", 64'(bus.out_valid), 64'd1);
        rst_l = 1'b0;
        #1;
        check("midrst_out_valid", 64'(bus.out_valid), 64'd0);
        check("midrst_fflags",    64'(fflags_acc),    64'd0);
        check("midrst_out_no",    64'(bus.out_no),    64'd0);
        sb.delete();
        to_pos();
        rst_l = 1'b1;
        bus.out_ready = 1'b1;

        // After reset req0 wins a simultaneous request.
        set_req(0, 1'b1, V_C, 1'b0, RM_RNE, 5'd10, 32'h40000000, 3'b000);
        set_req(1, 1'b1, V_C, 1'b0, RM_RNE, 5'd11, 32'h40000000, 3'b000);
        at_neg();
        check("post_rst_rdy0", 64'(bus.req0_ready), 64'd1);
        check("post_rst_rdy1", 64'(bus.req1_ready), 64'd0);
        to_pos();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        at_neg();
        to_pos();
        check("sb_drained", 64'(sb.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
